dmem_dma: RTL

DMEM_DMA -- requirements
Module: dmem_dma

---
 rtl/dmem_dma_pkg.sv | 22 ++
 rtl/dmem_dma.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_dma_pkg.sv
// dmem_dma_pkg: shared types and constants for the data-memory copy engine.
// Holds the FSM state encoding, word size and peripheral address map.
package dmem_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int unsigned WORD_BYTES  = 4;
    localparam logic [31:0] PTR_STEP    = 32'(WORD_BYTES);
    localparam logic [31:0] SWITCH_ADDR = 32'hC000_0000;
    localparam logic [31:0] LED_ADDR    = 32'hC000_0004;

    // Byte address points at the first byte of a 32-bit word
    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_dma.sv
// dmem_dma: word-by-word copy engine on the single-port data memory.
// Alternates READ/WRITE cycles; rejects misaligned or oversized requests.
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [6:0]  len_words,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic        req_empty;
    logic        last_word;

    // Request qualification against the live inputs
    always_comb begin
        req_bad   = !word_aligned(src_addr)
                 || !word_aligned(dst_addr)
                 || (32'(len_words) > MAX_WORDS);
        req_empty = (len_words == 7'd0);
        last_word = (cnt_q == 7'd1);
    end

    // State register; reset wins over any pending start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_bad || req_empty) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: latch request, capture read data, advance pointers
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        err_d  = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    cnt_d = len_words;
                    err_d = req_bad;
                end
            end
            ST_READ: begin
                data_d = mem_rd;
            end
            ST_WRITE: begin
                src_d = src_q + PTR_STEP;
                dst_d = dst_q + PTR_STEP;
                cnt_d = cnt_q - 7'd1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    // Outputs from state; reset gates strobes so an abort never writes
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        err    = err_q;
        unique case (state_q)
            ST_READ: begin
                busy  = 1'b1;
                mem_a = src_q;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_we = !reset;
                mem_a  = dst_q;
                mem_wd = data_q;
            end
            ST_FINISH: begin
                done = !reset;
            end
            default: begin
            end
        endcase
    end

endmodule
